siso_frame_rx: RTL and testbench

- Serial-to-parallel frame receiver directly downstream of the SISO shift register.
- Consumes the register's serial output one bit per clock, detects framed words and checks parity and stop bits.
- Presents each received word on a single-entry parallel output buffer with a valid/ready handshake.

---
 rtl/siso_frame_rx.sv | 160 ++++++++++++++++
 tb/tb_siso_frame_rx.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/siso_frame_rx.sv
// Serial frame receiver sitting behind the SISO shift register.
// Recovers framed words from a one-bit-per-clock stream, checks even parity
// and the stop bit, and holds each word in a single-entry valid/ready buffer.
//
// Frame on SI (idle level 0): start(1), DATA_W data bits LSB first,
// optional even-parity bit, stop(0).
//
// Ports:
//   clk        rising-edge clock
//   clear      synchronous active-high reset
//   SI         serial input, sampled every rising edge
//   data_out   received word, bit 0 = first data bit on the line
//   data_perr  parity error flag for the word in data_out
//   data_valid data_out/data_perr hold an unconsumed word
//   data_ready consumer takes the word on data_valid && data_ready
//   frame_err  one-cycle pulse: stop bit sampled as 1, word discarded
//   overrun    one-cycle pulse: good frame dropped because buffer was full
module siso_frame_rx #(
    parameter int unsigned DATA_W    = 8,
    parameter bit          PARITY_EN = 1'b1
) (
    input  logic              clk,
    input  logic              clear,
    input  logic              SI,
    output logic [DATA_W-1:0] data_out,
    output logic              data_perr,
    output logic              data_valid,
    input  logic              data_ready,
    output logic              frame_err,
    output logic              overrun
);

    localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] shift_q;
    logic              par_q;

    logic              stop_edge_c;
    logic              load_c;
    logic              accept_c;
    logic              frame_err_c;
    logic              overrun_c;

    // State register
    always_ff @(posedge clk) begin
        if (clear) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and buffer-control decode
    always_comb begin
        state_d     = state_q;
        stop_edge_c = 1'b0;
        load_c      = 1'b0;
        frame_err_c = 1'b0;
        overrun_c   = 1'b0;
        accept_c    = data_valid && data_ready;

        case (state_q)
            IDLE: begin
                if (SI) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (cnt_q == CNT_LAST) begin
                    if (PARITY_EN) begin
                        state_d = PARITY;
                    end else begin
                        state_d = STOP;
                    end
                end
            end
            PARITY: begin
                state_d = STOP;
            end
            STOP: begin
                // A 1 here is a framing error, never a new start bit.
                state_d     = IDLE;
                stop_edge_c = 1'b1;
                if (SI) begin
                    frame_err_c = 1'b1;
                end else if (!data_valid || data_ready) begin
                    load_c = 1'b1;
                end else begin
                    overrun_c = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Bit collection: counter, shift register, running parity
    always_ff @(posedge clk) begin
        if (clear) begin
            cnt_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    par_q <= 1'b0;
                end
                DATA: begin
                    shift_q[cnt_q] <= SI;
                    par_q          <= par_q ^ SI;
                    cnt_q          <= cnt_q + CNT_W'(1);
                end
                PARITY: begin
                    par_q <= par_q ^ SI;
                end
                default: begin
                    cnt_q <= '0;
                end
            endcase
        end
    end

    // Output buffer and status pulses
    always_ff @(posedge clk) begin
        if (clear) begin
            data_out   <= '0;
            data_perr  <= 1'b0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            frame_err <= frame_err_c;
            overrun   <= overrun_c;
            if (load_c) begin
                data_out   <= shift_q;
                data_perr  <= PARITY_EN & par_q;
                data_valid <= 1'b1;
            end else if (accept_c) begin
                data_valid <= 1'b0;
            end
        end
    end

    logic unused_c;
    assign unused_c = stop_edge_c;

endmodule

// File: tb/tb_siso_frame_rx.sv
module tb_siso_frame_rx;

    logic       clk = 1'b0;
    logic       clear;
    logic       si_a;
    logic       ready_a;
    logic [7:0] data_a;
    logic       perr_a;
    logic       valid_a;
    logic       ferr_a;
    logic       ovr_a;

    logic       si_b;
    logic       ready_b;
    logic [3:0] data_b;
    logic       perr_b;
    logic       valid_b;
    logic       ferr_b;
    logic       ovr_b;

    int n_chk  = 0;
    int n_fail = 0;
    bit started = 1'b0;

    always #5 clk = ~clk;

    siso_frame_rx #(.DATA_W(8), .PARITY_EN(1'b1)) dut_a (
        .clk        (clk),
        .clear      (clear),
        .SI         (si_a),
        .data_out   (data_a),
        .data_perr  (perr_a),
        .data_valid (valid_a),
        .data_ready (ready_a),
        .frame_err  (ferr_a),
        .overrun    (ovr_a)
    );

    siso_frame_rx #(.DATA_W(4), .PARITY_EN(1'b0)) dut_b (
        .clk        (clk),
        .clear      (clear),
        .SI         (si_b),
        .data_out   (data_b),
        .data_perr  (perr_b),
        .data_valid (valid_b),
        .data_ready (ready_b),
        .frame_err  (ferr_b),
        .overrun    (ovr_b)
    );

    // Reference model: tracks position within a frame by offset from the
    // start bit and evaluates the whole frame once the stop offset is reached.
    typedef struct {
        int          pos;
        logic [15:0] fb;
        logic        valid;
        logic [7:0]  data;
        logic        perr;
        logic        ferr;
        logic        ovr;
    } model_t;

    model_t ma;
    model_t mb;

    task automatic step(input int dw, input int pe, input logic clr,
                        input logic si, input logic rdy,
                        input model_t mi, output model_t mo);
        model_t m;
        bit     loaded;
        int     ones;
        m      = mi;
        m.ferr = 1'b0;
        m.ovr  = 1'b0;
        loaded = 1'b0;
        if (clr) begin
            m.pos   = -1;
            m.fb    = '0;
            m.valid = 1'b0;
            m.data  = '0;
            m.perr  = 1'b0;
        end else begin
            if (m.pos < 0) begin
                if (si) m.pos = 0;
            end else begin
                m.fb[m.pos] = si;
                m.pos++;
                if (m.pos == dw + pe + 1) begin
                    if (si) begin
                        m.ferr = 1'b1;
                    end else if (!m.valid || rdy) begin
                        ones = 0;
                        for (int k = 0; k < dw + pe; k++) ones += int'(m.fb[k]);
                        m.data = '0;
                        for (int k = 0; k < dw; k++) m.data[k] = m.fb[k];
                        m.perr  = (pe != 0) && (ones % 2 == 1);
                        m.valid = 1'b1;
                        loaded  = 1'b1;
                    end else begin
                        m.ovr = 1'b1;
                    end
                    m.pos = -1;
                end
            end
            if (mi.valid && rdy && !loaded) m.valid = 1'b0;
        end
        mo = m;
    endtask

    always @(posedge clk) begin
        step(8, 1, clear, si_a, ready_a, ma, ma);
        step(4, 0, clear, si_b, ready_b, mb, mb);
        if (clear) started = 1'b1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (started) begin
            chk("a_valid", 32'(valid_a), 32'(ma.valid));
            chk("a_data",  32'(data_a),  32'(ma.data));
            chk("a_perr",  32'(perr_a),  32'(ma.perr));
            chk("a_ferr",  32'(ferr_a),  32'(ma.ferr));
            chk("a_ovr",   32'(ovr_a),   32'(ma.ovr));
            chk("b_valid", 32'(valid_b), 32'(mb.valid));
            chk("b_data",  32'(data_b),  32'(mb.data));
            chk("b_perr",  32'(perr_b),  32'(mb.perr));
            chk("b_ferr",  32'(ferr_b),  32'(mb.ferr));
            chk("b_ovr",   32'(ovr_b),   32'(mb.ovr));
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send_a(input logic [7:0] w, input logic p, input logic s);
        si_a = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) begin
            si_a = w[i];
            tick();
        end
        si_a = p;
        tick();
        si_a = s;
        tick();
        si_a = 1'b0;
    endtask

    task automatic send_b(input logic [3:0] w);
        si_b = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            si_b = w[i];
            tick();
        end
        si_b = 1'b0;
        tick();
    endtask

    initial begin
        logic [7:0] w7e;
        clear   = 1'b1;
        si_a    = 1'b0;
        si_b    = 1'b0;
        ready_a = 1'b1;
        ready_b = 1'b1;
        @(negedge clk);
        tick();
        clear = 1'b0;
        chk("rst_valid", 32'(valid_a), 32'd0);
        chk("rst_data",  32'(data_a),  32'd0);

        // 1: 0xA5, correct parity
        repeat (3) tick();
        send_a(8'hA5, 1'b0, 1'b0);
        chk("t1_valid", 32'(valid_a), 32'd1);
        chk("t1_data",  32'(data_a),  32'hA5);
        chk("t1_perr",  32'(perr_a),  32'd0);
        chk("t1_ferr",  32'(ferr_a),  32'd0);
        tick();
        chk("t1_consumed", 32'(valid_a), 32'd0);

        // 2: 0x01 with wrong parity bit
        send_a(8'h01, 1'b0, 1'b0);
        chk("t2_valid", 32'(valid_a), 32'd1);
        chk("t2_data",  32'(data_a),  32'h01);
        chk("t2_perr",  32'(perr_a),  32'd1);
        tick();

        // 3: overrun with back-to-back frames, consumer stalled
        ready_a = 1'b0;
        send_a(8'h3C, 1'b0, 1'b0);
        chk("t3_valid1", 32'(valid_a), 32'd1);
        chk("t3_data1",  32'(data_a),  32'h3C);
        send_a(8'hC3, 1'b0, 1'b0);
        chk("t3_ovr",    32'(ovr_a),   32'd1);
        chk("t3_data2",  32'(data_a),  32'h3C);
        tick();
        chk("t3_ovr_pulse", 32'(ovr_a), 32'd0);
        ready_a = 1'b1;
        tick();
        chk("t3_drop", 32'(valid_a), 32'd0);

        // 4: bad stop bit, then a good frame after one idle bit
        send_a(8'h5A, 1'b0, 1'b1);
        chk("t4_ferr",  32'(ferr_a),  32'd1);
        chk("t4_valid", 32'(valid_a), 32'd0);
        tick();
        chk("t4_ferr_pulse", 32'(ferr_a), 32'd0);
        send_a(8'h12, 1'b0, 1'b0);
        chk("t4_data",  32'(data_a),  32'h12);
        chk("t4_valid2", 32'(valid_a), 32'd1);

        // 5: clear mid-frame after the 4th data bit of 0x7E
        w7e  = 8'h7E;
        si_a = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            si_a = w7e[i];
            tick();
        end
        si_a  = w7e[4];
        clear = 1'b1;
        tick();
        clear = 1'b0;
        si_a  = 1'b0;
        chk("t5_rst_valid", 32'(valid_a), 32'd0);
        chk("t5_rst_data",  32'(data_a),  32'd0);
        chk("t5_rst_ferr",  32'(ferr_a),  32'd0);
        send_a(8'h7E, 1'b0, 1'b0);
        chk("t5_data",  32'(data_a),  32'h7E);
        chk("t5_valid", 32'(valid_a), 32'd1);
        tick();

        // 6: DATA_W=4, no parity, back-to-back 0x9 then 0x6
        send_b(4'h9);
        chk("t6_valid1", 32'(valid_b), 32'd1);
        chk("t6_data1",  32'(data_b),  32'h9);
        send_b(4'h6);
        chk("t6_valid2", 32'(valid_b), 32'd1);
        chk("t6_data2",  32'(data_b),  32'h6);
        chk("t6_perr",   32'(perr_b),  32'd0);
        tick();
        chk("t6_consumed", 32'(valid_b), 32'd0);
        repeat (2) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
